systolic_tile_sequencer: RTL
============================

Name: systolic_tile_sequencer

Overview:
Sequences one matrix tile through the ARR_SIZE x ARR_SIZE systolic array, in four steps:
- reads ARR_SIZE weight rows from the weight buffer into the array;
- streams K input vectors from the input buffer;
- flushes the skewed wavefront;
- drains the accumulator into the output buffer.
It sits between the controller (which issues start/config after decoding an instruction) and the weight buffer, input buffer, MAC array and accumulator.

Parameters:
ARR_SIZE, 4, array dimension N (rows = columns)
ADDR_W, 16, weight/input buffer address width
OP_ADDR_W, 4, output buffer / accumulator address width
K_W, 8, width of the tile depth field k_len

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request a tile; accepted only in IDLE
abort  input  1  synchronous cancel of the tile in progress
k_len  input  K_W  number of input vectors to stream; sampled with start
inp_base  input  ADDR_W  first input buffer address; sampled with start
wt_base  input  ADDR_W  first weight buffer address; sampled with start
op_base  input  OP_ADDR_W  first output buffer address; sampled with start
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on tile completion
err  output  1  one-cycle pulse on rejected start (k_len==0)
wt_rd_en  output  1  weight buffer read strobe
wt_addr  output  ADDR_W  weight buffer read address
wt_load  output  1  array latches weight row (wt_rd_en delayed 1 cycle)
wt_row  output  $clog2(ARR_SIZE)  target row for wt_load
inp_rd_en  output  1  input buffer read strobe
inp_addr  output  ADDR_W  input buffer read address
mac_en  output  1  array/accumulator advance enable
inp_valid  output  1  array input data valid (inp_rd_en delayed 1 cycle)
acc_clr  output  1  clear accumulator contents
acc_store_en  output  1  accumulator writes one result to the output buffer
acc_op_addr  output  OP_ADDR_W  output buffer address for acc_store_en

Behaviour:
- Reset (rst=1 at edge): state=IDLE, all counters 0. All outputs 0 from the next cycle. rst mid-tile discards the tile; no done is issued.
- Registered outputs. Buffer read latency is 1 cycle; wt_load and inp_valid are the read strobes delayed 1 cycle.
- States: IDLE, LOAD_W, STREAM, FLUSH, DRAIN, DONE.
- IDLE:
  - start=1 and k_len!=0: latch config; next state LOAD_W.
  - start=1 and k_len==0: err=1 for 1 cycle; stay IDLE.
- LOAD_W, N cycles, r=0..N-1:
  - wt_rd_en=1, wt_addr=wt_base+r (mod 2^ADDR_W).
  - acc_clr=1 on r=0 only.
  - wt_load/wt_row=r follow one cycle later; the last wt_load overlaps the first STREAM cycle.
- STREAM, k_len cycles, k=0..k_len-1:
  - inp_rd_en=1, inp_addr=inp_base+k (mod 2^ADDR_W).
  - mac_en=1 from the second STREAM cycle onward.
- FLUSH, fixed 2N cycles:
  - mac_en=1, inp_valid=1 only in the first FLUSH cycle (delayed last read), otherwise 0.
  - Covers 1 latency cycle + 2N-1 skew cycles.
- DRAIN, N cycles, i=0..N-1:
  - acc_store_en=1, acc_op_addr=op_base+i (mod 2^OP_ADDR_W, wraps e.g. 14,15,0,1).
  - mac_en=0.
- DONE: 1 cycle, done=1, busy=1; then IDLE. start during DONE is ignored.
- Timing: start sampled at edge 0 gives done high in cycle 4N+k_len+1. For N=4, k_len=8 this is cycle 25.
- start while busy: ignored; config registers unchanged.
- abort=1 in any non-IDLE state:
  - next cycle IDLE, all strobes 0, no done, no err;
  - pending delayed wt_load/inp_valid are also squashed.
- abort and start in the same IDLE cycle: abort wins, no tile starts.
- rst has priority over abort and start.
- Counters sized to hold N-1, 2N-1 and 2^K_W-1 without overflow. k_len=2^K_W-1 is legal.

Decomposition:
- Shared package accel_pkg holds:
  - state enum (IDLE, LOAD_W, STREAM, FLUSH, DRAIN, DONE);
  - default widths ADDR_W=16, OP_ADDR_W=4;
  - localparam FLUSH_CYCLES=2*ARR_SIZE.
- One sub-module: seq_phase_counter. It is a loadable down-counter with a last-cycle flag, shared by LOAD_W, STREAM, FLUSH and DRAIN. All other logic stays in the top.

Test Plan:
1. rst, then start with k_len=8, wt_base=0x0100, inp_base=0x0200, op_base=2 (N=4) -> wt_addr 0x100..0x103 in cycles 1-4, acc_clr in cycle 1 only, inp_addr 0x200..0x207 in cycles 5-12, acc_op_addr 2,3,4,5 in cycles 21-24, done in cycle 25, busy cycles 1-25.
2. start with k_len=0 -> err pulse next cycle, busy stays 0, no read strobes.
3. op_base=14, wt_base=0xFFFE, k_len=1 -> wt_addr FFFE,FFFF,0000,0001; acc_op_addr 14,15,0,1; done in cycle 18.
4. abort in cycle 7 (STREAM) -> cycle 8 IDLE, all strobes 0, no done. A new start then completes normally with a fresh acc_clr.
5. second start pulsed during STREAM and DONE -> ignored, config unchanged, a single done. Back-to-back start the cycle after DONE is accepted.
6. rst asserted during DRAIN -> next cycle all outputs 0, IDLE, no done.

Source files
------------

// File: rtl/accel_pkg.sv
// accel_pkg: shared sequencer state encoding and default widths for the accelerator datapath.
package accel_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, FLUSH, DRAIN, DONE} state_t;
  localparam int DEF_ARR_SIZE = 4;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_OP_ADDR_W = 4;
  localparam int DEF_K_W = 8;
  localparam int FLUSH_CYCLES = 2 * DEF_ARR_SIZE;
  function automatic int flush_len(input int n);
    return 2 * n;
  endfunction
endpackage

// File: rtl/seq_phase_counter.sv
// seq_phase_counter: loadable down-counter flagging the final cycle of a sequencer phase.
module seq_phase_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - W'(1);
  end
  assign last = cnt == '0;
endmodule

// File: rtl/systolic_tile_sequencer.sv
// systolic_tile_sequencer: walks one tile through weight load, input stream, wavefront flush and accumulator drain.
module systolic_tile_sequencer
  import accel_pkg::*;
#(
  parameter int ARR_SIZE = DEF_ARR_SIZE,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int OP_ADDR_W = DEF_OP_ADDR_W,
  parameter int K_W = DEF_K_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [K_W-1:0]              k_len,
  input  logic [ADDR_W-1:0]           inp_base,
  input  logic [ADDR_W-1:0]           wt_base,
  input  logic [OP_ADDR_W-1:0]        op_base,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic                        wt_rd_en,
  output logic [ADDR_W-1:0]           wt_addr,
  output logic                        wt_load,
  output logic [$clog2(ARR_SIZE)-1:0] wt_row,
  output logic                        inp_rd_en,
  output logic [ADDR_W-1:0]           inp_addr,
  output logic                        mac_en,
  output logic                        inp_valid,
  output logic                        acc_clr,
  output logic                        acc_store_en,
  output logic [OP_ADDR_W-1:0]        acc_op_addr
);
  localparam int RW = $clog2(ARR_SIZE);
  localparam int FLUSH_N = flush_len(ARR_SIZE);
  localparam int FW = $clog2(FLUSH_N);
  localparam int CW = K_W > FW ? K_W : FW;
  state_t state, nxt;
  logic [K_W-1:0] k_len_q;
  logic [ADDR_W-1:0] inp_base_q;
  logic [OP_ADDR_W-1:0] op_base_q;
  logic [RW-1:0] rd_row;
  logic [CW-1:0] phase_len;
  logic accept, squash, phase_last, phase_load;
  assign accept = state == IDLE && start && !abort && k_len != '0;
  assign squash = abort && state != IDLE;
  always_comb begin
    nxt = state;
    if (squash) nxt = IDLE;
    else begin
      unique case (state)
        IDLE:    nxt = accept ? LOAD_W : IDLE;
        LOAD_W:  nxt = phase_last ? STREAM : LOAD_W;
        STREAM:  nxt = phase_last ? FLUSH : STREAM;
        FLUSH:   nxt = phase_last ? DRAIN : FLUSH;
        DRAIN:   nxt = phase_last ? DONE : DRAIN;
        default: nxt = IDLE;
      endcase
    end
    phase_load = nxt != state;
    phase_len = nxt == STREAM ? CW'(k_len_q) - CW'(1) :
                nxt == FLUSH  ? CW'(FLUSH_N - 1) : CW'(ARR_SIZE - 1);
  end
  seq_phase_counter #(.W(CW)) u_phase (
    .clk(clk), .rst(rst), .load(phase_load), .load_val(phase_len), .last(phase_last)
  );
  // Every output is computed from the next state so it is registered yet aligned with its phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k_len_q <= '0;
      inp_base_q <= '0;
      op_base_q <= '0;
      rd_row <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      acc_clr <= 1'b0;
      wt_rd_en <= 1'b0;
      wt_addr <= '0;
      wt_load <= 1'b0;
      wt_row <= '0;
      inp_rd_en <= 1'b0;
      inp_addr <= '0;
      inp_valid <= 1'b0;
      mac_en <= 1'b0;
      acc_store_en <= 1'b0;
      acc_op_addr <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        k_len_q <= k_len;
        inp_base_q <= inp_base;
        op_base_q <= op_base;
      end
      busy <= nxt != IDLE;
      done <= nxt == DONE;
      err <= state == IDLE && start && !abort && k_len == '0;
      acc_clr <= accept;
      wt_rd_en <= nxt == LOAD_W;
      wt_addr <= nxt != LOAD_W ? '0 : state == LOAD_W ? wt_addr + ADDR_W'(1) : wt_base;
      rd_row <= (nxt == LOAD_W && state == LOAD_W) ? rd_row + RW'(1) : '0;
      wt_load <= wt_rd_en && !squash;
      wt_row <= (wt_rd_en && !squash) ? rd_row : '0;
      inp_rd_en <= nxt == STREAM;
      inp_addr <= nxt != STREAM ? '0 : state == STREAM ? inp_addr + ADDR_W'(1) : inp_base_q;
      inp_valid <= inp_rd_en && !squash;
      mac_en <= (nxt == STREAM && state == STREAM) || nxt == FLUSH;
      acc_store_en <= nxt == DRAIN;
      acc_op_addr <= nxt != DRAIN ? '0 : state == DRAIN ? acc_op_addr + OP_ADDR_W'(1) : op_base_q;
    end
  end
endmodule
